// File: rtl/rv32i_types_pkg.sv
// Shared core types: CDB result bundle, functional-unit select, FU count.
// Imported by the CDB arbiter and its result FIFO.
package rv32i_types;

    localparam int ROB_IDX_BITS  = 5;
    localparam int CDB_PD_BITS   = 6;
    localparam int ARCH_REG_BITS = 5;
    localparam int NUM_FU        = 3;

    typedef struct packed {
        logic                     valid;
        logic [ROB_IDX_BITS-1:0]  rob_idx;
        logic [CDB_PD_BITS-1:0]   pd_s;
        logic [ARCH_REG_BITS-1:0] rd_s;
        logic [31:0]              rd_v;
    } cdb_t;

    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2
    } fu_sel_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: DEPTH-entry cdb_t result FIFO with same-edge push/pop and flush.
// Ports: clk, rst, flush, push, pop, din -> head (oldest entry), count.
module cdb_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cdb_t                     din,
    output cdb_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cdb_t           mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    // A pop in the same edge frees a slot, so a push into a full FIFO is legal then.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges add/mul/div results onto one registered CDB, round-robin,
// with per-FU FIFOs, bypass, issue back-pressure (ready_*) and sticky overflow_err.
// Ports: clk, rst, flush, cdb_add/mul/div in; ready_add/mul/div, cdb_out, overflow_err out.
// Optional CDB_ARB_PERF_EN adds stall_cycles_add/mul/div saturating 32-bit counters.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int QUEUE_DEPTH   = 4,
    parameter int PHYS_REG_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  cdb_t        cdb_add,
    input  cdb_t        cdb_mul,
    input  cdb_t        cdb_div,
    output logic        ready_add,
    output logic        ready_mul,
    output logic        ready_div,
    output cdb_t        cdb_out,
    output logic        overflow_err
`ifdef CDB_ARB_PERF_EN
   ,output logic [31:0] stall_cycles_add,
    output logic [31:0] stall_cycles_mul,
    output logic [31:0] stall_cycles_div
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] RDY_MAX  = CW'(QUEUE_DEPTH - 2);

    cdb_t              in_a   [NUM_FU];
    cdb_t              head_a [NUM_FU];
    cdb_t              cand_d [NUM_FU];
    logic [CW-1:0]     cnt    [NUM_FU];
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] drop;
    logic [NUM_FU-1:0] rdy;
    cdb_t              win;
    cdb_t              out_q;
    fu_sel_t           rr_q;
    fu_sel_t           rr_d;
    logic              ovf_q;

    assign in_a[0] = cdb_add;
    assign in_a[1] = cdb_mul;
    assign in_a[2] = cdb_div;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        logic empty;
        logic full;

        assign empty = (cnt[i] == '0);
        assign full  = (cnt[i] == FULL_CNT);

        // Head of queue has priority; the live input competes only when empty.
        assign cand[i]   = !empty || in_a[i].valid;
        assign cand_d[i] = empty ? in_a[i] : head_a[i];

        assign pop[i]  = grant[i] && !empty;
        // A bypassed winner goes straight to the CDB and is not queued.
        assign push[i] = in_a[i].valid && !(grant[i] && empty);
        assign drop[i] = in_a[i].valid && full && !pop[i];
        assign rdy[i]  = (cnt[i] <= RDY_MAX);

        cdb_fifo #(
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_a[i]),
            .head  (head_a[i]),
            .count (cnt[i])
        );
    end

    assign ready_add = rdy[0];
    assign ready_mul = rdy[1];
    assign ready_div = rdy[2];

    always_comb begin
        grant = '0;
        unique case (rr_q)
            FU_ADD: begin
                if      (cand[0]) grant = 3'b001;
                else if (cand[1]) grant = 3'b010;
                else if (cand[2]) grant = 3'b100;
            end
            FU_MUL: begin
                if      (cand[1]) grant = 3'b010;
                else if (cand[2]) grant = 3'b100;
                else if (cand[0]) grant = 3'b001;
            end
            FU_DIV: begin
                if      (cand[2]) grant = 3'b100;
                else if (cand[0]) grant = 3'b001;
                else if (cand[1]) grant = 3'b010;
            end
            default: grant = '0;
        endcase
    end

    always_comb begin
        win  = '0;
        rr_d = rr_q;
        unique case (1'b1)
            grant[0]: begin
                win  = cand_d[0];
                rr_d = FU_MUL;
            end
            grant[1]: begin
                win  = cand_d[1];
                rr_d = FU_DIV;
            end
            grant[2]: begin
                win  = cand_d[2];
                rr_d = FU_ADD;
            end
            default: begin
                win  = '0;
                rr_d = rr_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            rr_q  <= FU_ADD;
            ovf_q <= 1'b0;
        end else if (flush) begin
            out_q.valid <= 1'b0;
        end else begin
            if (|grant) begin
                out_q.valid   <= 1'b1;
                out_q.rob_idx <= win.rob_idx;
                out_q.pd_s    <= win.pd_s[PHYS_REG_BITS-1:0];
                out_q.rd_s    <= win.rd_s;
                out_q.rd_v    <= win.rd_v;
            end else begin
                out_q.valid <= 1'b0;
            end
            rr_q <= rr_d;
            if (|drop) ovf_q <= 1'b1;
        end
    end

    assign cdb_out      = out_q;
    assign overflow_err = ovf_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] stall_q [NUM_FU];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) stall_q[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (cand[i] && !grant[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 32'd1;
                end
            end
        end
    end

    assign stall_cycles_add = stall_q[0];
    assign stall_cycles_mul = stall_q[1];
    assign stall_cycles_div = stall_q[2];
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, QUEUE_DEPTH 4).
// Ends with one CHECKS/ERRORS summary line.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    cdb_t cdb_add;
    cdb_t cdb_mul;
    cdb_t cdb_div;
    logic ready_add;
    logic ready_mul;
    logic ready_div;
    cdb_t cdb_out;
    logic overflow_err;
`ifdef CDB_ARB_PERF_EN
    logic [31:0] st_add;
    logic [31:0] st_mul;
    logic [31:0] st_div;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .QUEUE_DEPTH   (4),
        .PHYS_REG_BITS (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .cdb_add      (cdb_add),
        .cdb_mul      (cdb_mul),
        .cdb_div      (cdb_div),
        .ready_add    (ready_add),
        .ready_mul    (ready_mul),
        .ready_div    (ready_div),
        .cdb_out      (cdb_out),
        .overflow_err (overflow_err)
`ifdef CDB_ARB_PERF_EN
       ,.stall_cycles_add (st_add),
        .stall_cycles_mul (st_mul),
        .stall_cycles_div (st_div)
`endif
    );

    // Distinct payload per (fu, idx): rob_idx = fu*8 + idx.
    function automatic cdb_t mk(input int fu, input int idx);
        cdb_t c;
        c.valid   = 1'b1;
        c.rob_idx = 5'(fu * 8 + idx);
        c.pd_s    = 6'(fu * 8 + idx + 32);
        c.rd_s    = 5'(fu + idx + 1);
        c.rd_v    = 32'hC0DE_0000 | 32'(fu << 8) | 32'(idx);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cdb_add = '0;
        cdb_mul = '0;
        cdb_div = '0;
    endtask

    task automatic chk_cdb(input string tag, input cdb_t exp);
        checks++;
        assert (cdb_out === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, cdb_out, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic [2:0] exp);
        checks++;
        assert ({ready_div, ready_mul, ready_add} === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag,
                   {ready_div, ready_mul, ready_add}, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    cdb_t one;
    cdb_t zero_c;

    initial begin
        rst    = 1'b0;
        flush  = 1'b0;
        zero_c = '0;
        idle_inputs();

        // Reset state
        do_reset();
        chk_cdb("reset_out", zero_c);
        chk_ready("reset_ready", 3'b111);
        chk_bit("reset_ovf", overflow_err, 1'b0);

        // Single add, bypass, 1-cycle latency
        one.valid   = 1'b1;
        one.rob_idx = 5'd5;
        one.pd_s    = 6'd12;
        one.rd_s    = 5'd3;
        one.rd_v    = 32'hDEAD_BEEF;
        cdb_add = one;
        tick();
        chk_cdb("single_add", one);
        chk_ready("single_ready", 3'b111);
        idle_inputs();
        tick();
        chk_bit("single_gone", cdb_out.valid, 1'b0);
        tick();
        chk_bit("single_no_dup", cdb_out.valid, 1'b0);

        // Three-way collision from pointer add
        do_reset();
        cdb_add = mk(0, 1);
        cdb_mul = mk(1, 2);
        cdb_div = mk(2, 3);
        tick();
        idle_inputs();
        chk_cdb("coll_1", mk(0, 1));
        tick();
        chk_cdb("coll_2", mk(1, 2));
        tick();
        chk_cdb("coll_3", mk(2, 3));
        tick();
        chk_bit("coll_idle", cdb_out.valid, 1'b0);
        cdb_add = mk(0, 7);
        cdb_mul = mk(1, 7);
        tick();
        idle_inputs();
        chk_cdb("coll_ptr_add", mk(0, 7));
        tick();
        chk_cdb("coll_ptr_mul", mk(1, 7));

        // Fairness: add and mul every cycle for 8 cycles
        do_reset();
        for (int e = 0; e < 8; e++) begin
            cdb_add = mk(0, e);
            cdb_mul = mk(1, e);
            tick();
            chk_cdb($sformatf("fair_%0d", e), mk(e % 2, e / 2));
            if (e == 4) chk_bit("fair_rdy_add_hi", ready_add, 1'b1);
            if (e == 5) chk_bit("fair_rdy_add_lo", ready_add, 1'b0);
        end
        idle_inputs();
        for (int e = 8; e < 16; e++) begin
            tick();
            chk_cdb($sformatf("fair_%0d", e), mk(e % 2, e / 2));
        end
        tick();
        chk_bit("fair_done", cdb_out.valid, 1'b0);
        chk_bit("fair_ovf", overflow_err, 1'b0);

        // Overflow: flood all three FUs for 7 cycles
        do_reset();
        for (int e = 0; e < 7; e++) begin
            cdb_add = mk(0, e);
            cdb_mul = mk(1, e);
            cdb_div = mk(2, e);
            tick();
            chk_cdb($sformatf("ovf_out_%0d", e), mk(e % 3, e / 3));
            if (e == 5) begin
                chk_bit("ovf_pre", overflow_err, 1'b0);
                chk_ready("ovf_full_ready", 3'b000);
            end
        end
        idle_inputs();
        chk_bit("ovf_set", overflow_err, 1'b1);
        for (int k = 7; k < 19; k++) begin
            tick();
            chk_cdb($sformatf("ovf_out_%0d", k), mk(k % 3, k / 3));
        end
        tick();
        chk_bit("ovf_dropped", cdb_out.valid, 1'b0);
        chk_bit("ovf_sticky", overflow_err, 1'b1);

        // Reset mid-stream
        for (int e = 0; e < 3; e++) begin
            cdb_add = mk(0, e);
            cdb_mul = mk(1, e);
            cdb_div = mk(2, e);
            tick();
        end
        chk_bit("mid_busy", cdb_out.valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cdb("mid_rst_out", zero_c);
        chk_ready("mid_rst_ready", 3'b111);
        chk_bit("mid_rst_ovf", overflow_err, 1'b0);
        idle_inputs();
        cdb_div = mk(2, 6);
        tick();
        idle_inputs();
        chk_cdb("mid_first", mk(2, 6));
        tick();
        chk_bit("mid_no_stale", cdb_out.valid, 1'b0);

        // Flush with div holding 3 entries
        do_reset();
        for (int e = 0; e < 4; e++) begin
            cdb_add = mk(0, e);
            cdb_mul = mk(1, e);
            cdb_div = mk(2, e);
            tick();
        end
        chk_bit("fl_rdy_div_lo", ready_div, 1'b0);
        idle_inputs();
        cdb_add = mk(0, 6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_inputs();
        chk_bit("fl_out_inv", cdb_out.valid, 1'b0);
        chk_ready("fl_ready", 3'b111);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_bit($sformatf("fl_no_stale_%0d", k), cdb_out.valid, 1'b0);
        end
        cdb_add = mk(0, 5);
        cdb_mul = mk(1, 5);
        cdb_div = mk(2, 5);
        tick();
        idle_inputs();
        chk_cdb("fl_ptr_kept", mk(1, 5));
        chk_bit("fl_ovf", overflow_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
